// File: rtl/adain_pkg.sv
// Shared constants and state encoding for the AdaIN normalisation-exponent scan.
package adain_pkg;

    localparam int N_MAX        = 128;
    localparam int WIDTH_MAC_IN = 48;
    localparam int SCAN_BITS    = 8;

    localparam int WIDTH_N    = $clog2(N_MAX + 1);
    localparam int LZ_W       = $clog2(WIDTH_MAC_IN);
    localparam int LZN_W      = $clog2(WIDTH_N);
    localparam int NCHUNK     = WIDTH_MAC_IN / SCAN_BITS;
    localparam int K_W        = $clog2(NCHUNK);
    localparam int MAX_LZ_VAR = WIDTH_MAC_IN - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adain_lzc_scan_if.sv
// Handshake and result bundle between the variance producer/consumer and the LZC scan.
interface adain_lzc_scan_if;
    import adain_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH_MAC_IN-1:0] var_in;
    logic [WIDTH_N-1:0]      n_count;
    logic                    out_valid;
    logic                    out_ready;
    logic [LZN_W-1:0]        lead_zero_N;
    logic [LZ_W-1:0]         lead_zero_var;
    logic                    var_zero;
    logic                    n_error;
    logic                    busy;

    modport master (
        output in_valid, var_in, n_count, out_ready,
        input  in_ready, out_valid, lead_zero_N, lead_zero_var, var_zero, n_error, busy
    );

    modport slave (
        input  in_valid, var_in, n_count, out_ready,
        output in_ready, out_valid, lead_zero_N, lead_zero_var, var_zero, n_error, busy
    );

endinterface

// File: rtl/lzc_chunk.sv
// Leading-zero count of one scan chunk; returns W when the chunk is all zero.
module lzc_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0]          din,
    output logic [$clog2(W+1)-1:0] cnt
);
    localparam int CW = $clog2(W + 1);

    // Ascending walk so the highest set bit wins the final assignment.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/adain_lzc_scan.sv
// Iterative MSB-first leading-zero scan of the variance word plus log2(N) encode.
module adain_lzc_scan
    import adain_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    adain_lzc_scan_if.slave bus
);
    localparam int CLZ_W = $clog2(SCAN_BITS + 1);

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [WIDTH_MAC_IN-1:0] var_reg;
    logic [WIDTH_MAC_IN-1:0] var_shift;
    logic [SCAN_BITS-1:0]    chunk;
    logic [CLZ_W-1:0]        chunk_lz;
    logic [LZN_W-1:0]        lzn_comb, lzn_q;
    logic                    nerr_comb, nerr_q;
    logic [LZ_W-1:0]         lz_res, lz_var_q;
    logic                    zero_res, var_zero_q;
    logic                    accept, load_res;

    function automatic logic [LZ_W-1:0] sat_lz(input int lz);
        if (lz > MAX_LZ_VAR) return LZ_W'(MAX_LZ_VAR);
        return LZ_W'(lz);
    endfunction

    // Current chunk is brought to the top of the word so the select index stays constant.
    assign var_shift = var_reg << (int'(k_q) * SCAN_BITS);
    assign chunk     = var_shift[WIDTH_MAC_IN-1 -: SCAN_BITS];

    lzc_chunk #(.W(SCAN_BITS)) u_lzc (
        .din (chunk),
        .cnt (chunk_lz)
    );

    always_comb begin
        lzn_comb = '0;
        for (int i = 0; i < WIDTH_N; i++) begin
            if (bus.n_count[i]) lzn_comb = LZN_W'(i);
        end
        nerr_comb = (bus.n_count == '0) ||
                    ($countones(bus.n_count) != 1) ||
                    (bus.n_count > WIDTH_N'(N_MAX));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        accept   = 1'b0;
        load_res = 1'b0;
        lz_res   = '0;
        zero_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (chunk != '0) begin
                    load_res = 1'b1;
                    lz_res   = sat_lz(int'(k_q) * SCAN_BITS + int'(chunk_lz));
                    state_d  = DONE;
                end else if (k_q == K_W'(NCHUNK - 1)) begin
                    load_res = 1'b1;
                    lz_res   = LZ_W'(MAX_LZ_VAR);
                    zero_res = 1'b1;
                    state_d  = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            lzn_q      <= '0;
            nerr_q     <= 1'b0;
            lz_var_q   <= '0;
            var_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                lzn_q  <= lzn_comb;
                nerr_q <= nerr_comb;
            end
            if (load_res) begin
                lz_var_q   <= lz_res;
                var_zero_q <= zero_res;
            end
        end
    end

    // The variance word is pure data: only the accept strobe governs it.
    always_ff @(posedge clk) begin
        if (accept) var_reg <= bus.var_in;
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.lead_zero_N   = lzn_q;
    assign bus.lead_zero_var = lz_var_q;
    assign bus.var_zero      = var_zero_q;
    assign bus.n_error       = nerr_q;

endmodule
